// File: rtl/gate_vector_sequencer.sv
// -----------------------------------------------------------------------------
// gate_vector_sequencer
//
// Self-check controller for the XOR/XNOR/NOT/AND gate block. A run walks
// {a,b,c} through all 8 combinations. Each combination is held for
// HOLD_CYCLES settle cycles and then for one check cycle, in which the
// returned {d,e,f,y} is compared against the matching nibble of EXP_TABLE.
// At the end of a run a one-cycle done pulse is issued. The run also reports
// pass/fail, a mismatch count and the first failing vector.
//
// Parameters
//   HOLD_CYCLES  settle cycles per vector before sampling, legal range 1..15
//   EXP_TABLE    expected {d,e,f,y} for vector v={a,b,c} at [4v+3:4v]
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   begin a run (honoured only while idle, and not with abort)
//   abort       in   cancel a run in progress
//   d,e,f,y     in   gate block outputs under test
//   a,b,c       out  gate block stimulus, registered
//   busy        out  high while vectors are being settled/checked
//   done        out  one-cycle pulse at the end of a completed run
//   pass        out  last completed run had zero mismatches
//   err_count   out  mismatching vectors in current/last run (0..8)
//   fail_valid  out  at least one mismatch in current/last run
//   fail_vec    out  {a,b,c} of the first mismatch
// -----------------------------------------------------------------------------
module gate_vector_sequencer #(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter logic [31:0] EXP_TABLE   = 32'h5588AA66
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       fail_valid,
   output logic [2:0] fail_vec
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Last settle-counter value before moving on to the check cycle.
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state_q;
   logic [2:0] vec_q;
   logic [3:0] cnt_q;
   logic [2:0] abc_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [3:0] err_q;
   logic       fail_valid_q;
   logic [2:0] fail_vec_q;

   // Expected response table split into one nibble per vector.
   logic [3:0] exp_tbl [8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_exp
         assign exp_tbl[gi] = EXP_TABLE[4*gi +: 4];
      end
   endgenerate

   logic [3:0] sample_d;
   logic       mismatch_d;
   logic [3:0] err_inc_d;
   logic [2:0] vec_inc_d;

   assign sample_d   = {d, e, f, y};
   assign mismatch_d = (sample_d != exp_tbl[vec_q]);
   assign err_inc_d  = err_q + 4'd1;
   assign vec_inc_d  = vec_q + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         vec_q        <= 3'd0;
         cnt_q        <= 4'd0;
         abc_q        <= 3'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= 4'd0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= 3'd0;
      end else begin
         // done is a single-cycle pulse; only the CHECK->DONE transition raises it.
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_q      <= S_SETTLE;
                  vec_q        <= 3'd0;
                  cnt_q        <= 4'd0;
                  abc_q        <= 3'd0;
                  busy_q       <= 1'b1;
                  pass_q       <= 1'b0;
                  err_q        <= 4'd0;
                  fail_valid_q <= 1'b0;
                  fail_vec_q   <= 3'd0;
               end
            end

            S_SETTLE: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  abc_q   <= 3'd0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == HOLD_LAST) begin
                     state_q <= S_CHECK;
                  end
               end
            end

            S_CHECK: begin
               // Abort wins over the sample: the error state freezes as it was.
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  abc_q   <= 3'd0;
               end else begin
                  if (mismatch_d) begin
                     err_q <= err_inc_d;
                     if (!fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_vec_q   <= vec_q;
                     end
                  end
                  if (vec_q == 3'd7) begin
                     // pass must include the result of this final check.
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     abc_q   <= 3'd0;
                     pass_q  <= !mismatch_d && (err_q == 4'd0);
                  end else begin
                     state_q <= S_SETTLE;
                     vec_q   <= vec_inc_d;
                     abc_q   <= vec_inc_d;
                     cnt_q   <= 4'd0;
                  end
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign a          = abc_q[2];
   assign b          = abc_q[1];
   assign c          = abc_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_vector_sequencer
//
// Two sequencers (HOLD_CYCLES = 1 and 4) each face a behavioural gate block.
// The gate block's response can be corrupted by a per-vector XOR mask and a
// y stuck-at-0 option. The expected run result comes either from a vector
// table or from a reference model. That model counts the vectors whose
// response differs from the default truth table.
// -----------------------------------------------------------------------------
module tb_gate_vector_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0] start_s = '0;
   logic [1:0] abort_s = '0;
   logic [1:0] a_s, b_s, c_s, busy_s, done_s, pass_s, fv_s;
   logic [3:0] err_s  [2];
   logic [2:0] fvec_s [2];
   logic [3:0] resp_s [2];
   logic [31:0] mask_s [2];
   logic [1:0] sy_s = '0;

   int nvec = 0;
   int nerr = 0;

   // Behavioural gate block: d=a^b, e=~(a^b), f=~a, y=a&b, with optional faults.
   function automatic logic [3:0] gate_resp(input logic [2:0] v, input logic [31:0] m,
                                            input logic sy);
      logic [3:0]  r;
      logic [31:0] ms;
      r  = {v[2] ^ v[1], ~(v[2] ^ v[1]), ~v[2], v[2] & v[1]};
      ms = m >> (4 * v);
      r  = r ^ ms[3:0];
      if (sy) r[0] = 1'b0;
      return r;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         assign resp_s[gi] = gate_resp({a_s[gi], b_s[gi], c_s[gi]}, mask_s[gi], sy_s[gi]);
         gate_vector_sequencer #(
            .HOLD_CYCLES((gi == 0) ? 1 : 4),
            .EXP_TABLE  (32'h5588AA66)
         ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_s[gi]),
            .abort     (abort_s[gi]),
            .d         (resp_s[gi][3]),
            .e         (resp_s[gi][2]),
            .f         (resp_s[gi][1]),
            .y         (resp_s[gi][0]),
            .a         (a_s[gi]),
            .b         (b_s[gi]),
            .c         (c_s[gi]),
            .busy      (busy_s[gi]),
            .done      (done_s[gi]),
            .pass      (pass_s[gi]),
            .err_count (err_s[gi]),
            .fail_valid(fv_s[gi]),
            .fail_vec  (fvec_s[gi])
         );
      end
   endgenerate

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: compare every vector's response with the truth table.
   task automatic model(input logic [31:0] m, input logic sy, output logic [3:0] err,
                        output logic fv, output logic [2:0] fvec);
      logic [31:0] tbl;
      logic [31:0] ts;
      tbl  = 32'h5588AA66;
      err  = 4'd0;
      fv   = 1'b0;
      fvec = 3'd0;
      for (int v = 0; v < 8; v++) begin
         ts = tbl >> (4 * v);
         if (gate_resp(3'(v), m, sy) != ts[3:0]) begin
            err = err + 4'd1;
            if (!fv) begin
               fv   = 1'b1;
               fvec = 3'(v);
            end
         end
      end
   endtask

   task automatic chk_reset(input int u, input string nm);
      chk({nm, "_abc"},  32'({a_s[u], b_s[u], c_s[u]}), 32'd0);
      chk({nm, "_busy"}, 32'(busy_s[u]), 32'd0);
      chk({nm, "_done"}, 32'(done_s[u]), 32'd0);
      chk({nm, "_pass"}, 32'(pass_s[u]), 32'd0);
      chk({nm, "_err"},  32'(err_s[u]),  32'd0);
      chk({nm, "_fv"},   32'(fv_s[u]),   32'd0);
      chk({nm, "_fvec"}, 32'(fvec_s[u]), 32'd0);
   endtask

   // One full run: checks the a,b,c walk, busy, exact done timing and the
   // final result. start/abort are re-driven at cycle rp_at/ab_at after start.
   task automatic run_check(input int u, input logic [31:0] mask, input logic sy,
                            input int rp_at, input int ab_at, input logic [3:0] eerr,
                            input logic efv, input logic [2:0] efvec, input logic epass,
                            input string nm);
      int h;
      int lat;
      h   = (u == 0) ? 1 : 4;
      lat = 1 + 8 * (h + 1);
      mask_s[u] = mask;
      sy_s[u]   = sy;
      @(negedge clk);
      start_s[u] = 1'b1;
      for (int i = 1; i <= lat; i++) begin
         @(negedge clk);
         start_s[u] = (i == rp_at);
         abort_s[u] = (i == ab_at);
         if (i < lat) begin
            chk({nm, "_busy"}, 32'(busy_s[u]), 32'd1);
            chk({nm, "_done_early"}, 32'(done_s[u]), 32'd0);
            chk({nm, "_abc"}, 32'({a_s[u], b_s[u], c_s[u]}), 32'((i - 1) / (h + 1)));
         end else begin
            chk({nm, "_done_at_latency"}, 32'(done_s[u]), 32'd1);
            chk({nm, "_busy_in_done"}, 32'(busy_s[u]), 32'd0);
            chk({nm, "_abc_in_done"}, 32'({a_s[u], b_s[u], c_s[u]}), 32'd0);
         end
      end
      @(negedge clk);
      start_s[u] = 1'b0;
      abort_s[u] = 1'b0;
      chk({nm, "_done_pulse"}, 32'(done_s[u]), 32'd0);
      chk({nm, "_busy_after"}, 32'(busy_s[u]), 32'd0);
      chk({nm, "_pass"}, 32'(pass_s[u]), 32'(epass));
      chk({nm, "_err"}, 32'(err_s[u]), 32'(eerr));
      chk({nm, "_fv"}, 32'(fv_s[u]), 32'(efv));
      if (efv) chk({nm, "_fvec"}, 32'(fvec_s[u]), 32'(efvec));
      $display("run %s: unit %0d mask %08h sy %0d -> err %0d fv %0d fvec %0d pass %0d",
               nm, u, mask, sy, err_s[u], fv_s[u], fvec_s[u], pass_s[u]);
   endtask

   typedef struct {
      int          u;
      logic [31:0] mask;
      logic        sy;
      int          rp_at;
      int          ab_at;
      logic [3:0]  err;
      logic        fv;
      logic [2:0]  fvec;
      logic        pass;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [31:0] m;
      logic        sy;
      logic [3:0]  e_err;
      logic        e_fv;
      logic [2:0]  e_fvec;
      int          u;
      int          done_seen;

      //          unit  mask           sy    rp  ab  err  fv    fvec  pass
      tbl[0] = '{0, 32'h0000_0000, 1'b0, 0,  0,  4'd0, 1'b0, 3'd0, 1'b1}; // clean
      tbl[1] = '{0, 32'h0000_0000, 1'b1, 0,  0,  4'd2, 1'b1, 3'd6, 1'b0}; // y stuck-at-0
      tbl[2] = '{0, 32'h0000_000F, 1'b0, 3,  0,  4'd1, 1'b1, 3'd0, 1'b0}; // v0 bad, restart try
      tbl[3] = '{0, 32'hF000_0000, 1'b0, 17, 17, 4'd1, 1'b1, 3'd7, 1'b0}; // v7 bad, start+abort in DONE
      tbl[4] = '{0, 32'h1111_1111, 1'b0, 0,  0,  4'd8, 1'b1, 3'd0, 1'b0}; // all bad: count 8
      tbl[5] = '{0, 32'h0010_0100, 1'b0, 0,  0,  4'd2, 1'b1, 3'd2, 1'b0}; // v2,v5 bad
      tbl[6] = '{0, 32'h0000_0000, 1'b0, 0,  17, 4'd0, 1'b0, 3'd0, 1'b1}; // abort in DONE
      tbl[7] = '{1, 32'h0000_0000, 1'b0, 0,  0,  4'd0, 1'b0, 3'd0, 1'b1}; // H=4 clean
      tbl[8] = '{1, 32'h0F00_0000, 1'b0, 0,  0,  4'd1, 1'b1, 3'd6, 1'b0}; // H=4 v6 bad

      mask_s[0] = '0;
      mask_s[1] = '0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset(0, "reset_u0");
      chk_reset(1, "reset_u1");
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 9; k++) begin
         run_check(tbl[k].u, tbl[k].mask, tbl[k].sy, tbl[k].rp_at, tbl[k].ab_at,
                   tbl[k].err, tbl[k].fv, tbl[k].fvec, tbl[k].pass, $sformatf("tbl%0d", k));
      end

      // Abort 5 cycles into a run whose vector 0 mismatches.
      mask_s[0] = 32'h0000_000F;
      sy_s[0]   = 1'b0;
      @(negedge clk);
      start_s[0] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         start_s[0] = 1'b0;
      end
      abort_s[0] = 1'b1;
      @(negedge clk);
      abort_s[0] = 1'b0;
      chk("abort_busy", 32'(busy_s[0]), 32'd0);
      chk("abort_done", 32'(done_s[0]), 32'd0);
      chk("abort_abc", 32'({a_s[0], b_s[0], c_s[0]}), 32'd0);
      chk("abort_pass", 32'(pass_s[0]), 32'd0);
      chk("abort_err_frozen", 32'(err_s[0]), 32'd1);
      chk("abort_fv_frozen", 32'(fv_s[0]), 32'd1);
      chk("abort_fvec_frozen", 32'(fvec_s[0]), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_s[0] || busy_s[0]) done_seen++;
      end
      chk("abort_no_done_later", 32'(done_seen), 32'd0);
      chk("abort_err_still", 32'(err_s[0]), 32'd1);
      $display("run abort: err %0d fv %0d pass %0d", err_s[0], fv_s[0], pass_s[0]);
      run_check(0, 32'h0, 1'b0, 0, 0, 4'd0, 1'b0, 3'd0, 1'b1, "after_abort");

      // start together with abort while idle: ignored.
      start_s[0] = 1'b1;
      abort_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      abort_s[0] = 1'b0;
      chk("start_abort_idle_busy", 32'(busy_s[0]), 32'd0);
      @(negedge clk);
      chk("start_abort_idle_busy2", 32'(busy_s[0]), 32'd0);
      chk("start_abort_idle_pass", 32'(pass_s[0]), 32'd1);
      $display("run start+abort idle: busy %0d pass %0d", busy_s[0], pass_s[0]);

      // Synchronous reset mid-run while vector 3 is settling.
      mask_s[0] = 32'h0000_00F0;
      @(negedge clk);
      start_s[0] = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         start_s[0] = 1'b0;
      end
      chk("pre_rst_abc", 32'({a_s[0], b_s[0], c_s[0]}), 32'd3);
      chk("pre_rst_err", 32'(err_s[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset(0, "mid_rst");
      @(negedge clk);
      chk("mid_rst_idle", 32'(busy_s[0]), 32'd0);
      $display("run mid-run reset: busy %0d err %0d", busy_s[0], err_s[0]);

      // Randomised faults checked against the reference model.
      for (int k = 0; k < 20; k++) begin
         u = (k % 5 == 4) ? 1 : 0;
         m = '0;
         for (int v = 0; v < 8; v++) begin
            if ($urandom_range(1, 0) == 1) m[4*v +: 4] = 4'($urandom_range(15, 1));
         end
         sy = 1'($urandom_range(1, 0));
         model(m, sy, e_err, e_fv, e_fvec);
         run_check(u, m, sy, 0, 0, e_err, e_fv, e_fvec, (e_err == 4'd0),
                   $sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
